// File: rtl/dmem_ws_if.sv
// dmem_ws_if
//   CPU data-port bundle between a CPU-side requester and the dmem_ws memory.
//   master modport (CPU side):
//     REQ   out  access request
//     WE    out  1 = write, 0 = read
//     BE    out  byte enables, BE[i] selects WD[8i+7:8i]
//     ADDR  out  30-bit word address
//     WD    out  write data
//     RD    in   read data, valid with READY and held afterwards
//     READY in   one-cycle completion pulse
//     ERR   in   completed access was outside the memory window
//   slave modport (memory side): same signals, opposite directions.
interface dmem_ws_if;
   logic        REQ;
   logic        WE;
   logic [3:0]  BE;
   logic [29:0] ADDR;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        READY;
   logic        ERR;

   modport master (
      output REQ, WE, BE, ADDR, WD,
      input  RD, READY, ERR
   );

   modport slave (
      input  REQ, WE, BE, ADDR, WD,
      output RD, READY, ERR
   );
endinterface

// File: rtl/dmem_ws.sv
// dmem_ws
//   Word-addressed on-chip data memory with base-address decode, programmable
//   wait states and a REQ/READY handshake for the CPU data port.
//   Each accepted access spends WAIT_CYCLES+1 edges in BUSY, then one cycle in
//   DONE with READY high. Out-of-window accesses complete normally with ERR
//   high, never write memory and return RD = 0 for reads.
//
//   Parameters:
//     DEPTH_LOG2   log2 of the number of 32-bit words (4..16)
//     WAIT_CYCLES  extra wait states per access (0..15)
//     BASE_ADDR    word base address, aligned to 2**DEPTH_LOG2
//   Ports:
//     CLK    in   single clock, rising edge
//     RESET  in   synchronous, active-low reset (memory contents are kept)
//     bus    slave modport of dmem_ws_if (REQ/WE/BE/ADDR/WD in,
//            RD/READY/ERR out)
//   Build option:
//     DMEM_WS_POSTED_WRITE_EN  when defined, writes are committed at the accept
//                              edge and report READY one edge later; reads are
//                              unchanged.
module dmem_ws #(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [29:0] BASE_ADDR   = 30'h0
) (
   input logic      CLK,
   input logic      RESET,
   dmem_ws_if.slave bus
);

   localparam int         WORDS     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

`ifdef DMEM_WS_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            wcnt;
   logic [3:0]            wcnt_nxt;

   // latched request
   logic [DEPTH_LOG2-1:0] idx_q;
   logic                  we_q;
   logic [3:0]            be_q;
   logic [31:0]           wd_q;
   logic                  oow_q;

   logic [31:0]           rd_q;
   logic [31:0]           mem [0:WORDS-1];

   logic                  accept;
   logic                  posted_wr;
   logic                  perform;

   // memory write port
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wd;

   function automatic logic in_window(input logic [29-DEPTH_LOG2:0] hi);
      return hi == BASE_ADDR[29:DEPTH_LOG2];
   endfunction

   // next state / wait counter
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      accept    = 1'b0;
      posted_wr = 1'b0;
      perform   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.REQ) begin
               accept    = 1'b1;
               posted_wr = POSTED && bus.WE;
               state_nxt = BUSY;
               // a posted write is already in memory; its single BUSY cycle
               // only times the READY pulse
               wcnt_nxt  = (POSTED && bus.WE) ? 4'd0 : WAIT_LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (wcnt != 4'd0) begin
               wcnt_nxt = wcnt - 4'd1;
            end else begin
               perform   = 1'b1;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // memory write port select; a reset edge suppresses any write
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = idx_q;
      mem_be  = be_q;
      mem_wd  = wd_q;
      if (posted_wr) begin
         mem_we  = RESET && in_window(bus.ADDR[29:DEPTH_LOG2]);
         mem_idx = bus.ADDR[DEPTH_LOG2-1:0];
         mem_be  = bus.BE;
         mem_wd  = bus.WD;
      end else if (perform && we_q) begin
         mem_we  = RESET && !oow_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state <= IDLE;
         wcnt  <= 4'd0;
         rd_q  <= 32'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (perform && !we_q) begin
            rd_q <= oow_q ? 32'd0 : mem[idx_q];
         end
      end
   end

   // request capture; posted writes latch BE=0 so the completing edge is a no-op
   always_ff @(posedge CLK) begin
      if (accept) begin
         idx_q <= bus.ADDR[DEPTH_LOG2-1:0];
         we_q  <= bus.WE;
         be_q  <= posted_wr ? 4'b0000 : bus.BE;
         wd_q  <= bus.WD;
         oow_q <= !in_window(bus.ADDR[29:DEPTH_LOG2]);
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) begin
               mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
         end
      end
   end

   assign bus.RD    = rd_q;
   assign bus.READY = (state == DONE);
   assign bus.ERR   = (state == DONE) && oow_q;

endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws
//   Self-checking bench for dmem_ws (DEPTH_LOG2=10, WAIT_CYCLES=2,
//   BASE_ADDR=0). A word-array model of the memory and of the RD register
//   supplies expected read data, ERR and completion latency.
module tb_dmem_ws;

   localparam int          DL2   = 10;
   localparam int          W     = 2;
   localparam logic [29:0] BASE  = 30'h0;
   localparam int          WORDS = 1 << DL2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   logic [31:0] mdl [0:WORDS-1];
   logic [31:0] m_rd = 32'd0;

   dmem_ws_if bus ();

   dmem_ws #(
      .DEPTH_LOG2  (DL2),
      .WAIT_CYCLES (W),
      .BASE_ADDR   (BASE)
   ) dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic int exp_lat(input bit we);
`ifdef DMEM_WS_POSTED_WRITE_EN
      if (we) return 1;
`endif
      return W + 1;
   endfunction

   function automatic void model_access(input bit we, input logic [3:0] be,
                                        input logic [29:0] addr, input logic [31:0] wd,
                                        output logic [31:0] e_rd, output logic e_err);
      int unsigned a     = addr;
      int unsigned idx   = a % WORDS;
      bit          inwin = (a / WORDS) == (int'(BASE) / WORDS);
      logic [31:0] w;
      e_err = !inwin;
      if (we) begin
         if (inwin) begin
            w = mdl[idx];
            for (int i = 0; i < 4; i++)
               if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            mdl[idx] = w;
         end
      end else begin
         m_rd = inwin ? mdl[idx] : 32'd0;
      end
      e_rd = m_rd;
   endfunction

   // ---------------- driver ----------------
   // Issues one access, then scrambles the bus inputs while it is in flight.
   // lat = edges after the accept edge until READY is seen; stray flags READY
   // or ERR outside the single completion cycle.
   task automatic access(input bit we, input logic [3:0] be, input logic [29:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output bit stray);
      stray = 1'b0;
      @(negedge clk);
      bus.REQ  = 1'b1;
      bus.WE   = we;
      bus.BE   = be;
      bus.ADDR = addr;
      bus.WD   = wd;
      @(posedge clk);
      @(negedge clk);
      if (bus.READY || bus.ERR) stray = 1'b1;
      bus.REQ  = 1'b0;
      bus.WE   = 1'($urandom);
      bus.BE   = 4'($urandom);
      bus.ADDR = 30'($urandom);
      bus.WD   = $urandom;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.READY) break;
         if (bus.ERR) stray = 1'b1;
      end
      rd  = bus.RD;
      err = bus.ERR;
      @(posedge clk);
      @(negedge clk);
      if (bus.READY || bus.ERR) stray = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bit seen;
      bus.REQ = 1'b1; bus.WE = 1'b1; bus.BE = 4'hF; bus.ADDR = 30'd3; bus.WD = 32'hCAFE0001;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (bus.READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready cyc%0d actual=%b required=0", k, bus.READY); end
         n_cmp++;
         if (bus.ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err cyc%0d actual=%b required=0", k, bus.ERR); end
         n_cmp++;
         if (bus.RD !== 32'd0) begin n_bad++; $display("FAIL reset_rd cyc%0d actual=%h required=00000000", k, bus.RD); end
      end
      reset   = 1'b1;
      bus.REQ = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.READY || bus.ERR) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept actual=READY_seen required=quiet"); end
   endtask

   task automatic test_fill();
      logic [31:0] rd, e_rd, wd;
      logic        err, e_err;
      int          lat;
      bit          stray;
      for (int a = 0; a < 16; a++) begin
         wd = $urandom;
         access(1'b1, 4'hF, 30'(a), wd, rd, err, lat, stray);
         model_access(1'b1, 4'hF, 30'(a), wd, e_rd, e_err);
         n_cmp++;
         if (lat !== exp_lat(1'b1) || err !== e_err || stray) begin
            n_bad++;
            $display("FAIL fill addr=%0d actual lat=%0d err=%b stray=%b required lat=%0d err=%b stray=0",
                     a, lat, err, stray, exp_lat(1'b1), e_err);
         end
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd, e_rd;
      logic        err, e_err;
      int          lat;
      bit          stray;
      access(1'b1, 4'hF, 30'd5, 32'hDEADBEEF, rd, err, lat, stray);
      model_access(1'b1, 4'hF, 30'd5, 32'hDEADBEEF, e_rd, e_err);
      n_cmp++;
      if (lat !== exp_lat(1'b1) || err !== 1'b0 || stray) begin
         n_bad++;
         $display("FAIL wr_complete actual lat=%0d err=%b stray=%b required lat=%0d err=0 stray=0",
                  lat, err, stray, exp_lat(1'b1));
      end
      access(1'b0, 4'h0, 30'd5, 32'h0, rd, err, lat, stray);
      model_access(1'b0, 4'h0, 30'd5, 32'h0, e_rd, e_err);
      n_cmp++;
      if (lat !== W + 1 || err !== 1'b0 || stray) begin
         n_bad++;
         $display("FAIL rd_complete actual lat=%0d err=%b stray=%b required lat=%0d err=0 stray=0",
                  lat, err, stray, W + 1);
      end
      n_cmp++;
      if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data actual=%h required=deadbeef", rd); end
   endtask

   task automatic test_byte_enables();
      logic [31:0] rd, e_rd;
      logic        err, e_err;
      int          lat;
      bit          stray;
      logic [31:0] prev;
      access(1'b1, 4'b1111, 30'd7, 32'h11223344, rd, err, lat, stray);
      model_access(1'b1, 4'b1111, 30'd7, 32'h11223344, e_rd, e_err);
      prev = rd;
      access(1'b1, 4'b0101, 30'd7, 32'hAABBCCDD, rd, err, lat, stray);
      model_access(1'b1, 4'b0101, 30'd7, 32'hAABBCCDD, e_rd, e_err);
      n_cmp++;
      if (rd !== prev) begin n_bad++; $display("FAIL wr_keeps_rd actual=%h required=%h", rd, prev); end
      access(1'b0, 4'b0000, 30'd7, 32'h0, rd, err, lat, stray);
      model_access(1'b0, 4'b0000, 30'd7, 32'h0, e_rd, e_err);
      n_cmp++;
      if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL byte_merge actual=%h required=11bb33dd", rd); end
      // BE=0000 still completes and changes nothing
      access(1'b1, 4'b0000, 30'd7, 32'hFFFFFFFF, rd, err, lat, stray);
      model_access(1'b1, 4'b0000, 30'd7, 32'hFFFFFFFF, e_rd, e_err);
      n_cmp++;
      if (lat !== exp_lat(1'b1) || stray) begin
         n_bad++;
         $display("FAIL be0_complete actual lat=%0d stray=%b required lat=%0d stray=0", lat, stray, exp_lat(1'b1));
      end
      access(1'b0, 4'b1111, 30'd7, 32'h0, rd, err, lat, stray);
      model_access(1'b0, 4'b1111, 30'd7, 32'h0, e_rd, e_err);
      n_cmp++;
      if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL be0_nowrite actual=%h required=11bb33dd", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e_rd;
      logic        e_err;
      int          lat;
      int          t_prev;
      bus.REQ = 1'b0;
      @(negedge clk);
      bus.REQ = 1'b1; bus.WE = 1'b0; bus.BE = 4'($urandom); bus.ADDR = 30'd0;
      t_prev = 0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         @(negedge clk);
         // REQ stays high through BUSY with a junk address
         bus.ADDR = 30'($urandom);
         lat = 0;
         while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.READY) break;
         end
         model_access(1'b0, 4'h0, 30'(j), 32'h0, e_rd, e_err);
         n_cmp++;
         if (lat !== W + 1) begin n_bad++; $display("FAIL b2b_lat idx=%0d actual=%0d required=%0d", j, lat, W + 1); end
         if (j > 0) begin
            n_cmp++;
            if (cyc - t_prev !== W + 2) begin
               n_bad++; $display("FAIL b2b_spacing idx=%0d actual=%0d required=%0d", j, cyc - t_prev, W + 2);
            end
         end
         t_prev = cyc;
         n_cmp++;
         if (bus.RD !== e_rd || bus.ERR !== 1'b0) begin
            n_bad++; $display("FAIL b2b_data idx=%0d actual rd=%h err=%b required rd=%h err=0", j, bus.RD, bus.ERR, e_rd);
         end
         if (j < 2) bus.ADDR = 30'(j + 1);
         else       bus.REQ  = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.READY !== 1'b0) begin n_bad++; $display("FAIL b2b_tail actual=%b required=0", bus.READY); end
   endtask

   task automatic test_out_of_window();
      logic [31:0] rd, e_rd, w0;
      logic        err, e_err;
      int          lat;
      bit          stray;
      w0 = mdl[0];
      access(1'b0, 4'hF, 30'h400, 32'h0, rd, err, lat, stray);
      model_access(1'b0, 4'hF, 30'h400, 32'h0, e_rd, e_err);
      n_cmp++;
      if (err !== 1'b1 || rd !== 32'd0 || lat !== W + 1 || stray) begin
         n_bad++;
         $display("FAIL oow_read actual err=%b rd=%h lat=%0d stray=%b required err=1 rd=00000000 lat=%0d stray=0",
                  err, rd, lat, stray, W + 1);
      end
      access(1'b1, 4'hF, 30'h400, ~w0, rd, err, lat, stray);
      model_access(1'b1, 4'hF, 30'h400, ~w0, e_rd, e_err);
      n_cmp++;
      if (err !== 1'b1 || lat !== exp_lat(1'b1) || stray) begin
         n_bad++;
         $display("FAIL oow_write actual err=%b lat=%0d stray=%b required err=1 lat=%0d stray=0",
                  err, lat, stray, exp_lat(1'b1));
      end
      access(1'b0, 4'hF, 30'h0, 32'h0, rd, err, lat, stray);
      model_access(1'b0, 4'hF, 30'h0, 32'h0, e_rd, e_err);
      n_cmp++;
      if (rd !== w0 || err !== 1'b0) begin
         n_bad++; $display("FAIL oow_no_alias actual rd=%h err=%b required rd=%h err=0", rd, err, w0);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, e_rd;
      logic        err, e_err;
      int          lat;
      bit          stray;
      bit          seen;
      access(1'b1, 4'hF, 30'd9, 32'h0, rd, err, lat, stray);
      model_access(1'b1, 4'hF, 30'd9, 32'h0, e_rd, e_err);
`ifdef DMEM_WS_POSTED_WRITE_EN
      access(1'b1, 4'hF, 30'd9, 32'h12345678, rd, err, lat, stray);
      model_access(1'b1, 4'hF, 30'd9, 32'h12345678, e_rd, e_err);
      n_cmp++;
      if (lat !== 1 || stray) begin n_bad++; $display("FAIL posted_lat actual=%0d stray=%b required=1 stray=0", lat, stray); end
`else
      @(negedge clk);
      bus.REQ = 1'b1; bus.WE = 1'b1; bus.BE = 4'hF; bus.ADDR = 30'd9; bus.WD = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      bus.REQ = 1'b0;
      reset   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_rd  = 32'd0;
      n_cmp++;
      if (bus.READY !== 1'b0 || bus.RD !== 32'd0) begin
         n_bad++; $display("FAIL midrst_state actual ready=%b rd=%h required ready=0 rd=00000000", bus.READY, bus.RD);
      end
      seen = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.READY || bus.ERR) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_ready actual=READY_seen required=quiet"); end
`endif
      access(1'b0, 4'hF, 30'd9, 32'h0, rd, err, lat, stray);
      model_access(1'b0, 4'hF, 30'd9, 32'h0, e_rd, e_err);
      n_cmp++;
      if (rd !== e_rd) begin n_bad++; $display("FAIL midrst_data actual=%h required=%h", rd, e_rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, e_rd, wd;
      logic        err, e_err;
      int          lat;
      bit          stray;
      bit          we;
      logic [3:0]  be;
      logic [29:0] addr;
      for (int n = 0; n < 60; n++) begin
         we = 1'($urandom);
         be = 4'($urandom);
         wd = $urandom;
         if ($urandom_range(0, 7) == 0) addr = 30'($urandom) | 30'h400;
         else                           addr = 30'($urandom_range(0, 15));
         access(we, be, addr, wd, rd, err, lat, stray);
         model_access(we, be, addr, wd, e_rd, e_err);
         n_cmp++;
         if (rd !== e_rd || err !== e_err || lat !== exp_lat(we) || stray) begin
            n_bad++;
            $display("FAIL rand n=%0d we=%b be=%h addr=%h actual rd=%h err=%b lat=%0d stray=%b required rd=%h err=%b lat=%0d stray=0",
                     n, we, be, addr, rd, err, lat, stray, e_rd, e_err, exp_lat(we));
         end
      end
   endtask

   initial begin
      bus.REQ = 1'b0; bus.WE = 1'b0; bus.BE = 4'h0; bus.ADDR = 30'h0; bus.WD = 32'h0;
      for (int i = 0; i < WORDS; i++) mdl[i] = 32'hx;
      test_reset();
      test_fill();
      test_write_read();
      test_byte_enables();
      test_back_to_back();
      test_out_of_window();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
